uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 21 ++
 rtl/uart_tx_arb_if.sv | 33 +++
 rtl/uart_tx_arb_rr_select.sv | 27 ++
 rtl/uart_tx_arb.sv | 120 ++++++++++++
 tb/tb_uart_tx_arb.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared UART package: FSM state encoding and width helper.
// Reused by the transmit arbiter and the receive-side blocks.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
// master = arbiter side, slave = requesters plus transmitter.
interface uart_tx_arb_if #(
  parameter int N        = 4,
  parameter int DATA_LEN = 8
);

  logic [N-1:0]          req;
  logic [N*DATA_LEN-1:0] req_data;
  logic [N-1:0]          ack;
  logic [DATA_LEN-1:0]   tx_data;
  logic                  tx_start;
  logic                  tx_ready;

  modport master (
    input  req,
    input  req_data,
    input  tx_ready,
    output ack,
    output tx_data,
    output tx_start
  );

  modport slave (
    output req,
    output req_data,
    output tx_ready,
    input  ack,
    input  tx_data,
    input  tx_start
  );

endinterface

// File: rtl/uart_tx_arb_rr_select.sv
// Rotating-priority selector: first set req bit at or after ptr.
// Purely combinational.
module rr_select
  import uart_tx_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] index,
  output logic         valid
);

  // Scan from the far end so the smallest offset from ptr wins.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        index = W'((int'(ptr) + i) % N);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding N byte requesters into one UART transmitter.
// Watches tx_ready for the busy/idle handshake; flags a stuck transmitter.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_LEN = 8,
  parameter int BUSY_TO  = 15,
  localparam int GW      = clog2(N),
  localparam int CW      = clog2(BUSY_TO + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_arb_if.master bus,
  output logic [GW-1:0] grant_id,
  output logic          busy,
  output logic          err
);

  state_t              state;
  state_t              state_n;
  logic [GW-1:0]       ptr;
  logic [GW-1:0]       ptr_nxt;
  logic [GW-1:0]       sel_idx;
  logic                sel_valid;
  logic [CW-1:0]       cnt;
  logic                timeout;
  logic [DATA_LEN-1:0] tx_data_q;
  logic [N-1:0]        ack_c;
  logic                tx_start_c;
  logic                grant;

  rr_select #(
    .N (N),
    .W (GW)
  ) u_sel (
    .req   (bus.req),
    .ptr   (ptr),
    .index (sel_idx),
    .valid (sel_valid)
  );

  assign grant   = bus.tx_ready && sel_valid;
  assign timeout = (cnt == CW'(BUSY_TO - 1));
  assign ptr_nxt = (grant_id == GW'(N - 1)) ? '0
                 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (grant) state_n = ISSUE;
      end
      ISSUE: state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.tx_ready) state_n = WAIT_DONE;
        else if (timeout)  state_n = IDLE;
      end
      WAIT_DONE: begin
        if (bus.tx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ack_c      = '0;
    tx_start_c = 1'b0;
    if (state == ISSUE) begin
      ack_c[grant_id] = 1'b1;
      tx_start_c      = 1'b1;
    end
  end

  assign bus.ack      = ack_c;
  assign bus.tx_start = tx_start_c;
  assign bus.tx_data  = tx_data_q;
  assign busy         = (state != IDLE);

  // Byte and index are latched at selection so requesters may move on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      grant_id  <= '0;
      tx_data_q <= '0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            grant_id  <= sel_idx;
            tx_data_q <= bus.req_data[int'(sel_idx)*DATA_LEN +: DATA_LEN];
          end
        end
        ISSUE: cnt <= '0;
        WAIT_BUSY: begin
          if (bus.tx_ready) begin
            if (timeout) begin
              err <= 1'b1;
              ptr <= ptr_nxt;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (bus.tx_ready) ptr <= ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (N=4, 8-bit, BUSY_TO=15).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_tx_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       busy;
  logic       err;
  int         total;
  int         bad;

  uart_tx_arb_if #(.N(4), .DATA_LEN(8)) bus ();

  uart_tx_arb #(
    .N        (4),
    .DATA_LEN (8),
    .BUSY_TO  (15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: from ISSUE, go busy one cycle, then ready again.
  task automatic tx_done();
    tick();
    bus.tx_ready = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_ready = 1'b1;
    repeat (2) tick();
    total++;
    if (bus.ack !== 4'b0 || bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses ack=%b start=%b exp 0", bus.ack, bus.tx_start);
    end
    total++;
    if (bus.tx_data !== 8'h00 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_regs data=%h gid=%0d exp 0", bus.tx_data, grant_id);
    end
    total++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags busy=%b err=%b exp 0", busy, err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.req      = 4'b0100;
    bus.req_data = {8'h11, 8'hA5, 8'h22, 8'h33};
    tick();
    total++;
    if (bus.tx_start !== 1'b1 || bus.ack !== 4'b0100) begin
      bad++;
      $display("FAIL single_pulse start=%b ack=%b exp 1/0100", bus.tx_start, bus.ack);
    end
    total++;
    if (bus.tx_data !== 8'hA5 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL single_sel data=%h gid=%0d exp a5/2", bus.tx_data, grant_id);
    end
    bus.req = '0;
    tick();
    total++;
    if (bus.tx_start !== 1'b0 || bus.ack !== 4'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_one_cycle start=%b ack=%b busy=%b exp 0/0/1", bus.tx_start, bus.ack, busy);
    end
    bus.tx_ready = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle busy=%b exp 0", busy);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_ack;
    int         cnt[4];
    logic [3:0] stray;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.req      = 4'b1111;
    bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    stray        = '0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_ack = 4'b0001 << (k % 4);
      total++;
      if (grant_id !== 2'(k % 4) || bus.ack !== exp_ack) begin
        bad++;
        $display("FAIL fair_order%0d gid=%0d ack=%b exp %0d/%b", k, grant_id, bus.ack, k % 4, exp_ack);
      end
      total++;
      if (bus.tx_data !== 8'((k % 4) * 8'h11 + 8'h10)) begin
        bad++;
        $display("FAIL fair_data%0d data=%h", k, bus.tx_data);
      end
      if (k < 4) begin
        for (int i = 0; i < 4; i++) cnt[i] += int'(bus.ack[i]);
      end
      tick();
      stray |= bus.ack;
      bus.tx_ready = 1'b0;
      tick();
      stray |= bus.ack;
      bus.tx_ready = 1'b1;
      tick();
      stray |= bus.ack;
    end
    bus.req = '0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cnt[i] !== 1) begin
        bad++;
        $display("FAIL fair_once%0d acks=%0d exp 1", i, cnt[i]);
      end
    end
    total++;
    if (stray !== 4'b0) begin
      bad++;
      $display("FAIL fair_stray ack=%b exp 0", stray);
    end
  endtask

  task automatic test_rotation_skip();
    bus.req      = 4'b1001;
    bus.req_data = {8'hD3, 8'h00, 8'h00, 8'hD0};
    tick();
    total++;
    if (grant_id !== 2'd3 || bus.tx_data !== 8'hD3) begin
      bad++;
      $display("FAIL skip_first gid=%0d data=%h exp 3/d3", grant_id, bus.tx_data);
    end
    bus.req = 4'b0001;
    tx_done();
    tick();
    total++;
    if (grant_id !== 2'd0 || bus.ack !== 4'b0001) begin
      bad++;
      $display("FAIL skip_second gid=%0d ack=%b exp 0/0001", grant_id, bus.ack);
    end
    bus.req = '0;
    tx_done();
  endtask

  task automatic test_stuck();
    bus.req      = 4'b0110;
    bus.req_data = {8'h00, 8'h62, 8'h61, 8'h00};
    tick();
    total++;
    if (grant_id !== 2'd1 || bus.tx_start !== 1'b1) begin
      bad++;
      $display("FAIL stuck_grant gid=%0d start=%b exp 1/1", grant_id, bus.tx_start);
    end
    bus.req = 4'b0100;
    for (int i = 1; i <= 15; i++) tick();
    total++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL stuck_early err=%b busy=%b exp 0/1", err, busy);
    end
    tick();
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stuck_timeout err=%b busy=%b exp 1/0", err, busy);
    end
    tick();
    total++;
    if (grant_id !== 2'd2 || bus.tx_data !== 8'h62 || err !== 1'b1) begin
      bad++;
      $display("FAIL stuck_next gid=%0d data=%h err=%b exp 2/62/1", grant_id, bus.tx_data, err);
    end
    bus.req = '0;
    tx_done();
  endtask

  task automatic test_reset_mid();
    bus.req      = 4'b0100;
    bus.req_data = {8'h00, 8'h77, 8'h00, 8'h00};
    tick();
    tick();
    bus.tx_ready = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1 || grant_id !== 2'd2) begin
      bad++;
      $display("FAIL rmid_pre busy=%b gid=%0d exp 1/2", busy, grant_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || err !== 1'b0 || grant_id !== 2'd0) begin
      bad++;
      $display("FAIL rmid_async busy=%b err=%b gid=%0d exp 0", busy, err, grant_id);
    end
    total++;
    if (bus.tx_data !== 8'h00 || bus.ack !== 4'b0 || bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL rmid_outs data=%h ack=%b start=%b exp 0", bus.tx_data, bus.ack, bus.tx_start);
    end
    bus.req      = '0;
    bus.tx_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (bus.tx_start !== 1'b0 || bus.ack !== 4'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rmid_quiet start=%b ack=%b busy=%b exp 0", bus.tx_start, bus.ack, busy);
    end
    bus.req      = 4'b1001;
    bus.req_data = {8'hE7, 8'h00, 8'h00, 8'h5A};
    tick();
    total++;
    if (grant_id !== 2'd0 || bus.tx_data !== 8'h5A || bus.ack !== 4'b0001) begin
      bad++;
      $display("FAIL rmid_fresh gid=%0d data=%h ack=%b exp 0/5a/0001", grant_id, bus.tx_data, bus.ack);
    end
    bus.req = '0;
    tx_done();
  endtask

  task automatic test_not_ready();
    bus.tx_ready = 1'b0;
    bus.req      = 4'b0001;
    bus.req_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || bus.tx_start !== 1'b0) begin
      bad++;
      $display("FAIL notready_hold busy=%b start=%b exp 0/0", busy, bus.tx_start);
    end
    bus.tx_ready = 1'b1;
    tick();
    total++;
    if (bus.tx_start !== 1'b1 || grant_id !== 2'd0 || bus.tx_data !== 8'h3C) begin
      bad++;
      $display("FAIL notready_go start=%b gid=%0d data=%h exp 1/0/3c", bus.tx_start, grant_id, bus.tx_data);
    end
    bus.req = '0;
    tx_done();
  endtask

  task automatic test_withdraw();
    logic [3:0] seen;
    bus.req      = 4'b0010;
    bus.req_data = {8'h00, 8'h00, 8'hC3, 8'h00};
    tick();
    total++;
    if (grant_id !== 2'd1 || bus.ack !== 4'b0010 || bus.tx_start !== 1'b1) begin
      bad++;
      $display("FAIL wd_issue gid=%0d ack=%b start=%b exp 1/0010/1", grant_id, bus.ack, bus.tx_start);
    end
    bus.req      = '0;
    bus.req_data = {8'h00, 8'h00, 8'hFF, 8'h00};
    tick();
    total++;
    if (bus.ack !== 4'b0 || bus.tx_data !== 8'hC3) begin
      bad++;
      $display("FAIL wd_hold ack=%b data=%h exp 0/c3", bus.ack, bus.tx_data);
    end
    bus.tx_ready = 1'b0;
    tick();
    bus.tx_ready = 1'b1;
    tick();
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= bus.ack;
      if (bus.tx_start === 1'b1 || busy === 1'b1) seen[0] = 1'b1;
    end
    total++;
    if (seen !== 4'b0) begin
      bad++;
      $display("FAIL wd_no_repeat act=%b exp 0", seen);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_fairness();
    test_rotation_skip();
    test_stuck();
    test_reset_mid();
    test_not_ready();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
